// File: rtl/jam_perm_gen.sv
// Lexicographic permutation source for 8 workers/jobs, one assignment per valid/ready handshake.
// Multi-cycle next-permutation step: pivot scan, successor scan, swap, then suffix reversal.
module jam_perm_gen (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        perm_ready,
  output logic        perm_valid,
  output logic [23:0] perm,
  output logic [15:0] perm_index,
  output logic        perm_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, PRESENT, PIVOT, SUCC, SWAP, REV} state_t;

  localparam logic [15:0] LAST_INDEX = 16'd40319;

  state_t      state, state_nxt;
  logic [2:0]  p     [8];
  logic [2:0]  p_nxt [8];
  logic [2:0]  i_q, i_nxt;
  logic [2:0]  j_q, j_nxt;
  logic [2:0]  lo_q, lo_nxt;
  logic [2:0]  hi_q, hi_nxt;
  logic [15:0] idx_q, idx_nxt;
  logic        done_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      for (int w = 0; w < 8; w++) p[w] <= 3'(w);
      i_q   <= '0;
      j_q   <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      idx_q <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      i_q   <= i_nxt;
      j_q   <= j_nxt;
      lo_q  <= lo_nxt;
      hi_q  <= hi_nxt;
      idx_q <= idx_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    i_nxt     = i_q;
    j_nxt     = j_q;
    lo_nxt    = lo_q;
    hi_nxt    = hi_q;
    idx_nxt   = idx_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          for (int w = 0; w < 8; w++) p_nxt[w] = 3'(w);
          idx_nxt   = '0;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (perm_ready) begin
          if (idx_q == LAST_INDEX) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            i_nxt     = 3'd6;
            state_nxt = PIVOT;
          end
        end
      end
      // The last permutation never reaches PIVOT, so a pivot always exists.
      PIVOT: begin
        if (p[i_q] < p[i_q + 3'd1]) begin
          j_nxt     = 3'd7;
          state_nxt = SUCC;
        end else begin
          i_nxt = i_q - 3'd1;
        end
      end
      SUCC: begin
        if (p[j_q] > p[i_q]) state_nxt = SWAP;
        else                 j_nxt     = j_q - 3'd1;
      end
      SWAP: begin
        p_nxt[i_q] = p[j_q];
        p_nxt[j_q] = p[i_q];
        lo_nxt     = i_q + 3'd1;
        hi_nxt     = 3'd7;
        if (i_q + 3'd1 < 3'd7) begin
          state_nxt = REV;
        end else begin
          idx_nxt   = idx_q + 16'd1;
          state_nxt = PRESENT;
        end
      end
      REV: begin
        p_nxt[lo_q] = p[hi_q];
        p_nxt[hi_q] = p[lo_q];
        lo_nxt      = lo_q + 3'd1;
        hi_nxt      = hi_q - 3'd1;
        if (lo_q + 3'd1 >= hi_q - 3'd1) begin
          idx_nxt   = idx_q + 16'd1;
          state_nxt = PRESENT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    perm = '0;
    for (int w = 0; w < 8; w++) perm[3*w +: 3] = p[w];
  end

  assign perm_valid = (state == PRESENT);
  assign perm_last  = (state == PRESENT) && (idx_q == LAST_INDEX);
  assign busy       = (state != IDLE);
  assign perm_index = idx_q;

endmodule

// File: tb/tb_jam_perm_gen.sv
// Scoreboard bench for jam_perm_gen: expected permutations and latencies come from a software next-permutation model.
module tb_jam_perm_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        perm_ready;
  logic        perm_valid;
  logic [23:0] perm;
  logic [15:0] perm_index;
  logic        perm_last;
  logic        busy;
  logic        done;

  jam_perm_gen dut (
    .CLK(CLK), .RST(RST), .start(start), .perm_ready(perm_ready),
    .perm_valid(perm_valid), .perm(perm), .perm_index(perm_index),
    .perm_last(perm_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] p;
    int          idx;
    logic        last;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_spur = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Textbook next-permutation; latency follows the pivot/successor/reverse cycle costs.
  function automatic void model_next(input logic [23:0] cur, output logic [23:0] nxt, output int lat);
    int a[8];
    int i, j, lo, hi, t;
    for (int w = 0; w < 8; w++) a[w] = int'(cur[3*w +: 3]);
    i = 6;
    while (i > 0 && a[i] > a[i+1]) i--;
    j = 7;
    while (j > i && a[j] < a[i]) j--;
    t = a[i]; a[i] = a[j]; a[j] = t;
    lo = i + 1; hi = 7;
    while (lo < hi) begin
      t = a[lo]; a[lo] = a[hi]; a[hi] = t;
      lo++; hi--;
    end
    lat = (7 - i) + (8 - j) + 1 + (7 - i) / 2;
    nxt = '0;
    for (int w = 0; w < 8; w++) nxt[3*w +: 3] = 3'(a[w]);
  endfunction

  task automatic reset_checks(input string tag);
    check_val({tag, "_valid"}, perm_valid, 0);
    check_val({tag, "_busy"},  busy, 0);
    check_val({tag, "_done"},  done, 0);
    check_val({tag, "_last"},  perm_last, 0);
    check_val({tag, "_perm"},  perm, 24'hFAC688);
    check_val({tag, "_index"}, perm_index, 0);
  endtask

  // mode 0: full enumeration with backpressure and a stray start at index 100
  // mode 1: restart, then reset while reversing towards index 2
  // mode 2: restart after reset, stop at the first permutation
  task automatic run(input int mode, output bit aborted);
    exp_t        e;
    logic [23:0] np;
    int          lat, cnt;
    bit          waiting, inject, force_rdy;
    aborted   = 1'b0;
    inject    = 1'b0;
    force_rdy = 1'b0;
    sb.delete();
    start = 1'b1;
    sb.push_back('{p: 24'hFAC688, idx: 0, last: 1'b0, lat: 0});
    waiting = 1'b1;
    cnt     = 0;
    forever begin
      @(negedge CLK);
      start = 1'b0;
      if (done) done_spur++;
      if (waiting) begin
        cnt++;
        if (inject && cnt == 1) begin
          check_val("busy_at_stray_start", busy, 1);
          start  = 1'b1;
          inject = 1'b0;
        end
        if (perm_valid) begin
          e = sb.pop_front();
          check_val("perm", perm, e.p);
          check_val("perm_index", perm_index, e.idx);
          check_val("perm_last", perm_last, e.last);
          check_val("latency", cnt - 1, e.lat);
          check_val("busy_present", busy, 1);
          waiting = 1'b0;
          if (mode == 0 && e.idx == 2) check_val("idx2_perm", perm, 24'hF74688);
          if (e.last) check_val("last_perm", perm, 24'h053977);
          if (mode == 2) begin
            perm_ready = 1'b0;
            return;
          end
          if (mode == 0 && e.idx == 1) begin
            perm_ready = 1'b0;
            repeat (10) begin
              @(negedge CLK);
              if (done) done_spur++;
              check_val("bp_perm", perm, 24'hDEC688);
              check_val("bp_index", perm_index, 1);
              check_val("bp_valid", perm_valid, 1);
            end
            force_rdy = 1'b1;
          end
        end else if (mode == 1 && cnt == 5 && sb.size() > 0 && sb[0].idx == 2) begin
          RST = 1'b1;
          @(negedge CLK);
          reset_checks("rst_mid");
          RST        = 1'b0;
          perm_ready = 1'b0;
          return;
        end else if (cnt > 40) begin
          check_val("valid_timeout", perm_valid, 1);
          aborted = 1'b1;
          return;
        end
      end
      if (!waiting) begin
        perm_ready = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
        force_rdy  = 1'b0;
        if (perm_ready) begin
          if (e.last) begin
            @(negedge CLK);
            check_val("done_pulse", done, 1);
            check_val("done_busy", busy, 0);
            check_val("done_valid", perm_valid, 0);
            perm_ready = 1'b0;
            @(negedge CLK);
            check_val("done_clear", done, 0);
            return;
          end
          model_next(e.p, np, lat);
          sb.push_back('{p: np, idx: e.idx + 1, last: (e.idx + 1 == 40319), lat: lat});
          waiting = 1'b1;
          cnt     = 0;
          if (mode == 0 && e.idx == 100) inject = 1'b1;
        end
      end
    end
  endtask

  initial begin
    bit ab;
    RST        = 1'b1;
    start      = 1'b0;
    perm_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset_checks("reset");
    RST = 1'b0;
    run(0, ab);
    if (!ab) check_val("done_spurious", done_spur, 0);
    if (!ab) run(1, ab);
    if (!ab) run(2, ab);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
